// File: rtl/rs_issue_sched_if.sv
// Scheduler <-> reservation-station bundle: RS entry state in, issue grants out.
// The RS side drives the master modport; the scheduler uses the slave modport.
interface rs_issue_sched_if #(
    parameter int RS_SZ = 16,
    parameter int N     = 2,
    parameter int IDX_W = $clog2(RS_SZ),
    parameter int CNT_W = $clog2(N + 1)
);
    logic [RS_SZ-1:0]          alloc_vec;
    logic [RS_SZ-1:0]          entry_valid;
    logic [RS_SZ-1:0]          entry_ready;
    logic [RS_SZ-1:0]          entry_is_mult;
    logic                      issue_stall;
    logic [RS_SZ-1:0]          issue_vec;
    logic [N-1:0]              issue_valid;
    logic [N-1:0][IDX_W-1:0]   issue_idx;
    logic [CNT_W-1:0]          cdb_reserved;

    modport master (
        output alloc_vec, entry_valid, entry_ready, entry_is_mult, issue_stall,
        input  issue_vec, issue_valid, issue_idx, cdb_reserved
    );

    modport slave (
        input  alloc_vec, entry_valid, entry_ready, entry_is_mult, issue_stall,
        output issue_vec, issue_valid, issue_idx, cdb_reserved
    );
endinterface

// File: rtl/rs_issue_sched.sv
// Oldest-first RS issue scheduler. Uses an age matrix and a shift register of
// future CDB slot reservations so that ALU and multiplier results share N broadcast slots.
module rs_issue_sched #(
    parameter int RS_SZ    = 16,
    parameter int N        = 2,
    parameter int NUM_MULT = 1,
    parameter int MULT_LAT = 4,
    parameter int IDX_W    = $clog2(RS_SZ)
) (
    input  logic               clock,
    input  logic               reset,
    rs_issue_sched_if.slave    bus
);
    localparam int CNT_W = $clog2(N + 1);

    // older[i][j] = 1 : entry i is older than entry j
    logic [RS_SZ-1:0][RS_SZ-1:0] older;
    logic [CNT_W-1:0]            res [1:MULT_LAT-1];
    logic [RS_SZ-1:0]            cand;
    logic [RS_SZ-1:0]            grant;
    logic [CNT_W-1:0]            mult_cnt;

    always_comb begin
        int rank;
        int m;
        int alu_allowed;
        cand  = bus.entry_valid & bus.entry_ready & ~bus.alloc_vec
              & {RS_SZ{~bus.issue_stall & ~reset}};
        grant = '0;
        m     = 0;
        for (int unsigned i = 0; i < RS_SZ; i++) begin
            rank = 0;
            for (int unsigned k = 0; k < RS_SZ; k++)
                if (cand[k] && bus.entry_is_mult[k] && older[k][i]) rank++;
            if (cand[i] && bus.entry_is_mult[i] && rank < NUM_MULT) begin
                grant[i] = 1'b1;
                m++;
            end
        end
        // ALU ops broadcast next cycle, so they share what the multipliers left free
        alu_allowed = N - m;
        if (N - int'(res[1]) < alu_allowed) alu_allowed = N - int'(res[1]);
        for (int unsigned i = 0; i < RS_SZ; i++) begin
            rank = 0;
            for (int unsigned k = 0; k < RS_SZ; k++)
                if (cand[k] && !bus.entry_is_mult[k] && older[k][i]) rank++;
            if (cand[i] && !bus.entry_is_mult[i] && rank < alu_allowed) grant[i] = 1'b1;
        end
        mult_cnt = CNT_W'(m);
    end

    always_comb begin
        int slot;
        bus.issue_valid = '0;
        bus.issue_idx   = '0;
        slot            = 0;
        for (int unsigned i = 0; i < RS_SZ; i++) begin
            if (grant[i] && slot < N) begin
                bus.issue_valid[slot] = 1'b1;
                bus.issue_idx[slot]   = IDX_W'(i);
                slot++;
            end
        end
    end

    assign bus.issue_vec    = grant;
    assign bus.cdb_reserved = reset ? '0 : res[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            older <= '0;
            for (int unsigned k = 1; k < MULT_LAT; k++) res[k] <= '0;
        end else begin
            for (int unsigned k = 1; k < MULT_LAT - 1; k++) res[k] <= res[k+1];
            res[MULT_LAT-1] <= mult_cnt;
            // Same-cycle allocations: lower index is older; row and column writes agree on shared bits
            for (int unsigned j = 0; j < RS_SZ; j++) begin
                if (bus.alloc_vec[j]) begin
                    for (int unsigned i = 0; i < RS_SZ; i++) begin
                        older[i][j] <= (bus.entry_valid[i] && !bus.alloc_vec[i])
                                     || (bus.alloc_vec[i] && i < j);
                        older[j][i] <= bus.alloc_vec[i] && i > j;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_sched.sv
// Bench for rs_issue_sched: directed cycle table for the corner sequences, then
// randomized traffic checked against an age-queue / broadcast-calendar reference model.
module tb_rs_issue_sched;
    localparam int RS_SZ    = 8;
    localparam int N        = 2;
    localparam int NUM_MULT = 1;
    localparam int MULT_LAT = 4;
    localparam int NRAND    = 600;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rs_issue_sched_if #(.RS_SZ(RS_SZ), .N(N)) bus ();

    rs_issue_sched #(
        .RS_SZ(RS_SZ), .N(N), .NUM_MULT(NUM_MULT), .MULT_LAT(MULT_LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave)
    );

    typedef struct {
        bit         rst;
        logic [7:0] alloc;
        logic [7:0] valid;
        logic [7:0] ready;
        logic [7:0] mult;
        bit         stall;
        logic [7:0] ev;
        int         er;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   order[$];
    int   bcast[0:NRAND+MULT_LAT+4];

    task automatic add(bit rst, logic [7:0] alloc, logic [7:0] valid, logic [7:0] ready,
                       logic [7:0] mult, bit stall, logic [7:0] ev, int er);
        vec_t v;
        v.rst = rst; v.alloc = alloc; v.valid = valid; v.ready = ready;
        v.mult = mult; v.stall = stall; v.ev = ev; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic chk(string name, int t, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%0h want=%0h", name, t, got, want);
        end
    endtask

    // {port valids, idx port1, idx port0}: granted indices in ascending order
    function automatic logic [7:0] exp_ports(input logic [7:0] v);
        logic [1:0] pv;
        logic [2:0] id [2];
        int s;
        pv = '0; id[0] = '0; id[1] = '0; s = 0;
        for (int i = 0; i < 8; i++)
            if (v[i] && s < N) begin
                pv[s] = 1'b1;
                id[s] = 3'(i);
                s++;
            end
        return {pv, id[1], id[0]};
    endfunction

    task automatic drive_check(string tag, int t, bit rst, logic [7:0] alloc, logic [7:0] valid,
                               logic [7:0] ready, logic [7:0] mult, bit stall,
                               logic [7:0] ev, int er);
        logic [7:0] ep;
        @(negedge clock);
        reset             = rst;
        bus.alloc_vec     = alloc;
        bus.entry_valid   = valid;
        bus.entry_ready   = ready;
        bus.entry_is_mult = mult;
        bus.issue_stall   = stall;
        #1;
        ep = exp_ports(ev);
        chk({tag, ".issue_vec"},    t, 32'(bus.issue_vec),    32'(ev));
        chk({tag, ".issue_valid"},  t, 32'(bus.issue_valid),  32'(ep[7:6]));
        chk({tag, ".issue_idx"},    t, 32'(bus.issue_idx),    32'(ep[5:0]));
        chk({tag, ".cdb_reserved"}, t, 32'(bus.cdb_reserved), er);
    endtask

    task automatic run_random();
        logic [7:0] live, mult, alloc, valid, ready, ev, sq;
        bit rst, stall;
        int m, a, allowed, e, er;
        int nq[$];
        live = '0; mult = '0;
        for (int k = 0; k <= NRAND + MULT_LAT + 4; k++) bcast[k] = 0;
        order.delete();
        for (int c = 0; c < NRAND; c++) begin
            rst   = (c == 0) || ($urandom_range(0, 49) == 0);
            alloc = '0;
            sq    = '0;
            for (int i = 0; i < RS_SZ; i++) begin
                if (!live[i] && $urandom_range(0, 2) == 0) begin
                    alloc[i] = 1'b1;
                    mult[i]  = 1'($urandom_range(0, 1));
                end
                if (live[i] && $urandom_range(0, 19) == 0) sq[i] = 1'b1;
            end
            valid = (live & ~sq) | alloc;
            ready = 8'($urandom);
            stall = ($urandom_range(0, 7) == 0);
            ev = '0; er = 0; m = 0;
            if (!rst) begin
                er = bcast[c+1];
                foreach (order[q]) begin
                    e = order[q];
                    if (valid[e] && ready[e] && !alloc[e] && !stall && mult[e] && m < NUM_MULT) begin
                        ev[e] = 1'b1;
                        m++;
                    end
                end
                allowed = N - m;
                if (N - bcast[c+1] < allowed) allowed = N - bcast[c+1];
                a = 0;
                foreach (order[q]) begin
                    e = order[q];
                    if (valid[e] && ready[e] && !alloc[e] && !stall && !mult[e] && a < allowed) begin
                        ev[e] = 1'b1;
                        a++;
                    end
                end
            end
            drive_check("rnd", c, rst, alloc, valid, ready, mult, stall, ev, er);
            if (rst) begin
                live = '0;
                order.delete();
                for (int k = c + 1; k <= NRAND + MULT_LAT + 4; k++) bcast[k] = 0;
            end else begin
                bcast[c+MULT_LAT] += m;
                live = valid & ~ev;
                nq.delete();
                foreach (order[q]) if (live[order[q]]) nq.push_back(order[q]);
                for (int i = 0; i < RS_SZ; i++) if (alloc[i]) nq.push_back(i);
                order = nq;
            end
        end
    endtask

    task automatic scen1();
        add(0, 8'h20, 8'h20, 8'h00, 8'h00, 0, 8'h00, 0);
        add(0, 8'h04, 8'h24, 8'h00, 8'h00, 0, 8'h00, 0);
        add(0, 8'h80, 8'hA4, 8'h00, 8'h00, 0, 8'h00, 0);
        add(0, 8'h00, 8'hA4, 8'hA4, 8'h00, 0, 8'h24, 0);
        add(0, 8'h00, 8'h80, 8'h80, 8'h00, 0, 8'h80, 0);
        add(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);
    endtask

    initial begin
        reset = 1'b1;
        bus.alloc_vec = '0; bus.entry_valid = '0; bus.entry_ready = '0;
        bus.entry_is_mult = '0; bus.issue_stall = 1'b0;

        add(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);
        add(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);
        scen1();
        // entry 6 older than same-cycle pair 3,1
        add(0, 8'h40, 8'h40, 8'h00, 8'h00, 0, 8'h00, 0);
        add(0, 8'h0A, 8'h4A, 8'h00, 8'h00, 0, 8'h00, 0);
        add(0, 8'h00, 8'h4A, 8'h4A, 8'h00, 0, 8'h42, 0);
        add(0, 8'h00, 8'h08, 8'h08, 8'h00, 0, 8'h08, 0);
        add(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);
        // two mults (0 older than 1) plus ALU 4; reservations appear 3 cycles later
        add(0, 8'h01, 8'h01, 8'h00, 8'h03, 0, 8'h00, 0);
        add(0, 8'h12, 8'h13, 8'h00, 8'h03, 0, 8'h00, 0);
        add(0, 8'h00, 8'h13, 8'h13, 8'h03, 0, 8'h11, 0);
        add(0, 8'h00, 8'h02, 8'h02, 8'h03, 0, 8'h02, 0);
        add(0, 8'h00, 8'h00, 8'h00, 8'h03, 0, 8'h00, 0);
        add(0, 8'h00, 8'h00, 8'h00, 8'h03, 0, 8'h00, 1);
        add(0, 8'h00, 8'h00, 8'h00, 8'h03, 0, 8'h00, 1);
        // mults in back-to-back cycles throttle later ALU issue to one per cycle
        add(0, 8'h03, 8'h03, 8'h00, 8'h03, 0, 8'h00, 0);
        add(0, 8'h3C, 8'h3F, 8'h03, 8'h03, 0, 8'h01, 0);
        add(0, 8'h00, 8'h3E, 8'h02, 8'h03, 0, 8'h02, 0);
        add(0, 8'h00, 8'h3C, 8'h00, 8'h03, 0, 8'h00, 0);
        add(0, 8'h00, 8'h3C, 8'h3C, 8'h03, 0, 8'h04, 1);
        add(0, 8'h00, 8'h38, 8'h38, 8'h03, 0, 8'h08, 1);
        add(0, 8'h00, 8'h30, 8'h30, 8'h03, 0, 8'h30, 0);
        add(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);
        // stall blocks grants while the reservation keeps shifting
        add(0, 8'h07, 8'h07, 8'h00, 8'h01, 0, 8'h00, 0);
        add(0, 8'h00, 8'h07, 8'h01, 8'h01, 0, 8'h01, 0);
        add(0, 8'h00, 8'h06, 8'h00, 8'h01, 0, 8'h00, 0);
        add(0, 8'h00, 8'h06, 8'h06, 8'h01, 1, 8'h00, 0);
        add(0, 8'h00, 8'h06, 8'h06, 8'h01, 1, 8'h00, 1);
        add(0, 8'h00, 8'h06, 8'h06, 8'h01, 0, 8'h06, 0);
        add(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);
        // reset with mults in flight drops their reservations
        add(0, 8'h03, 8'h03, 8'h00, 8'h03, 0, 8'h00, 0);
        add(0, 8'h00, 8'h03, 8'h03, 8'h03, 0, 8'h01, 0);
        add(0, 8'h00, 8'h02, 8'h02, 8'h03, 0, 8'h02, 0);
        add(1, 8'h00, 8'h04, 8'h04, 8'h03, 0, 8'h00, 0);
        add(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);
        add(0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 0);
        scen1();

        for (int t = 0; t < tbl.size(); t++)
            drive_check("dir", t, tbl[t].rst, tbl[t].alloc, tbl[t].valid, tbl[t].ready,
                        tbl[t].mult, tbl[t].stall, tbl[t].ev, tbl[t].er);

        run_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
